execute32: RTL and testbench
============================

Name: execute32

Overview:
- Execute (EX) stage of the Minisys-1A 5-stage MIPS pipeline.
- Selects forwarded operands and performs ALU, shift, compare and LUI operations.
- Owns the HI/LO registers: multiply, multi-cycle divide, MTHI/MTLO.
- Produces the write-back value and destination register, plus branch condition flags for the ID/EX→EX/MEM path.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles of the sequential divider.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- EX_opcplus4  in  32  PC+4 of the instruction; link value for JAL/JALR.
- EX_A, EX_B  in  32  rs/rt register-file values.
- EX_rd_data  in  32  rd register value; carried for the interface only, must not affect any output.
- EX_IMM  in  32  sign-extended immediate.
- EX_func  in  6  funct field.
- EX_op  in  6  opcode.
- EX_shamt  in  5  shift amount.
- EX_write_address_0  in  5  rt index.
- EX_write_address_1  in  5  rd index.
- EX_Aluop  in  2  00 = add, 01 = sub, 10 = decode by func/op.
- EX_Sftmd  in  1  shift instruction.
- EX_Div  in  1  DIV/DIVU instruction.
- EX_Alusrc  in  1  B operand is the immediate.
- AluAsrc, AluBsrc, AluMsrc  in  2 each  forward selects for A, B and store data.
- EX_I_format  in  1  I-type ALU instruction.
- EX_Jrn, EX_Jalr, EX_Jal  in  1 each  jump type.
- EX_Regdst  in  1  destination is rd.
- EX_Mfhi, EX_Mflo, EX_Mthi, EX_Mtlo  in  1 each  HI/LO operations.
- EX_MEM_ALU_result  in  32  forward source, one instruction ahead.
- Wdata  in  32  forward source, two instructions ahead (MEM/WB).
- rd_data  out  32  value to write back.
- EX_stall  out  1  divider busy; pipeline must hold.
- Zero, Positive, Negative, Overflow, Div_0  out  1 each  flags.
- Waddr  out  5  destination register.
- EX_ALU_result  out  32  ALU/shift result.
- EX_rt_data  out  32  forwarded rt, used as store data.

Behaviour:
- Forward muxes (A, B and M share one encoding): 00 = register value, 01 = EX_MEM_ALU_result, 10 = Wdata, 11 = register value. M applies to EX_B.
- B input: forwarded B, or EX_IMM when EX_Alusrc=1.
- Immediate extension: ANDI/ORI/XORI/SLTIU zero-extend EX_IMM[15:0]. Other immediates use EX_IMM as given.
- Aluop=00: A+B. Aluop=01: A−B.
- Aluop=10 with I_format, decoded by op[2:0]:
  - addi, addiu: add.
  - slti: signed set-less-than. sltiu: unsigned set-less-than.
  - andi, ori, xori.
  - lui: imm[15:0]<<16.
- Aluop=10 R-type, decoded by func:
  - add/addu, sub/subu, and, or, xor, nor.
  - slt (signed), sltu (unsigned).
- Shifts (EX_Sftmd=1), operand = forwarded B:
  - func[2:0] 000 sll, 010 srl, 011 sra use shamt.
  - 100 sllv, 110 srlv, 111 srav use A[4:0].
- Overflow: two's-complement overflow of add/addi/sub only; 0 for all other operations. No trap.
- Flags (all combinational):
  - Zero = (EX_ALU_result == 0).
  - Negative = A[31].
  - Positive = ~A[31] & (A ≠ 0).
- Waddr: 31 if EX_Jal; else EX_write_address_1 if EX_Regdst or EX_Jalr; else EX_write_address_0.
- rd_data priority: Jal|Jalr → EX_opcplus4; Mfhi → HI; Mflo → LO; else EX_ALU_result.
- HI/LO update at the clock edge:
  - MULT (signed) / MULTU (func 011000/011001): {HI,LO} = 64-bit product, single cycle.
  - MTHI/MTLO: load forwarded A.
- Divide (func 011010 signed / 011011 unsigned, EX_Div=1):
  - Sequential restoring divider, DIV_CYCLES iterations on magnitudes.
  - LO = quotient; HI = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- EX_stall = EX_Div & ~div_done.
  - div_done is a register set at the edge HI/LO are written and cleared on the next edge.
  - Upstream holds all inputs stable while EX_stall=1.
- Divisor = 0:
  - Div_0 = 1 combinationally.
  - No iteration, EX_stall = 0, HI/LO unchanged.
- Reset (async, reset=0): HI = LO = 0, divider idle, div_done = 0. All outputs are otherwise combinational.

Optional Feature:
- Macro DIVIDER_EN.
- Defined: divider as above.
- Undefined:
  - No divider logic; DIV/DIVU leave HI/LO unchanged.
  - EX_stall tied 0.
  - Div_0 still flags divisor = 0.

Test Plan:
- LUI: Aluop=10, I_format, op=001111, EX_IMM=FFFFFFFF → EX_ALU_result=FFFF0000; Waddr=8 (Regdst=0, write_address_0=8).
- ADDIU with AluAsrc=10, Wdata=0, IMM=0x3D → result 0x3D. Repeat with AluAsrc=01, EX_MEM_ALU_result=5 → 0x42.
- MULT: A=FFFF0000, AluBsrc=10, Wdata=0x3D, func=011000 → after edge HI=FFFFFFFF, LO=FFC30000. Then MFHI → rd_data=FFFFFFFF, Waddr=0x0A; MFLO → rd_data=FFC30000.
- SLL: B=1, shamt=6, Sftmd=1 → 0x40. SRA: B=80000000, shamt=4 → F8000000.
- BEQ: Aluop=01, A=0x0C, B=1 → result 0x0B, Zero=0. With A=B → Zero=1. ADD 7FFFFFFF+1 → Overflow=1.
- DIV: A=−7, B=2 → EX_stall high for DIV_CYCLES+1 cycles, then LO=FFFFFFFD, HI=FFFFFFFF. With B=0 → Div_0=1, no stall. Reset asserted mid-divide → HI=LO=0, stall drops.

Source files
------------

// File: rtl/execute32.sv
// execute32: EX stage of the Minisys-1A pipeline (forwarding, ALU, shifter, HI/LO).
// Define DIVIDER_EN to build the sequential divider; without it DIV/DIVU leave HI/LO untouched.
module execute32 #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] EX_opcplus4,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_B,
  input  logic [31:0] EX_rd_data,
  input  logic [31:0] EX_IMM,
  input  logic [5:0]  EX_func,
  input  logic [5:0]  EX_op,
  input  logic [4:0]  EX_shamt,
  input  logic [4:0]  EX_write_address_0,
  input  logic [4:0]  EX_write_address_1,
  input  logic [1:0]  EX_Aluop,
  input  logic        EX_Sftmd,
  input  logic        EX_Div,
  input  logic        EX_Alusrc,
  input  logic [1:0]  AluAsrc,
  input  logic [1:0]  AluBsrc,
  input  logic [1:0]  AluMsrc,
  input  logic        EX_I_format,
  input  logic        EX_Jrn,
  input  logic        EX_Jalr,
  input  logic        EX_Jal,
  input  logic        EX_Regdst,
  input  logic        EX_Mfhi,
  input  logic        EX_Mflo,
  input  logic        EX_Mthi,
  input  logic        EX_Mtlo,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] Wdata,
  output logic [31:0] rd_data,
  output logic        EX_stall,
  output logic        Zero,
  output logic        Positive,
  output logic        Negative,
  output logic        Overflow,
  output logic        Div_0,
  output logic [4:0]  Waddr,
  output logic [31:0] EX_ALU_result,
  output logic [31:0] EX_rt_data
);

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      2'b01:   return mem_val;
      2'b10:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

  logic [31:0] a_fwd, b_fwd, imm_ext, alu_b, add_res, sub_res, alu_out, shift_out;
  logic [31:0] hi, lo, div_hi, div_lo;
  logic [4:0]  sh_amt;
  logic        zero_ext, ovf_add, ovf_sub, alu_ovf, r_type, mult_op, div_zero, div_we;
  logic signed [65:0] product;

  assign a_fwd      = fwd_sel(AluAsrc, EX_A, EX_MEM_ALU_result, Wdata);
  assign b_fwd      = fwd_sel(AluBsrc, EX_B, EX_MEM_ALU_result, Wdata);
  assign EX_rt_data = fwd_sel(AluMsrc, EX_B, EX_MEM_ALU_result, Wdata);

  // Logical immediates and SLTIU treat the 16-bit field as unsigned.
  assign zero_ext = (EX_op == 6'b001100) || (EX_op == 6'b001101) ||
                    (EX_op == 6'b001110) || (EX_op == 6'b001011);
  assign imm_ext  = zero_ext ? {16'h0000, EX_IMM[15:0]} : EX_IMM;
  assign alu_b    = EX_Alusrc ? imm_ext : b_fwd;

  assign add_res = a_fwd + alu_b;
  assign sub_res = a_fwd - alu_b;
  assign ovf_add = (a_fwd[31] == alu_b[31]) && (add_res[31] != a_fwd[31]);
  assign ovf_sub = (a_fwd[31] != alu_b[31]) && (sub_res[31] != a_fwd[31]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (EX_Aluop)
      2'b00: alu_out = add_res;
      2'b01: alu_out = sub_res;
      2'b10: begin
        if (EX_I_format) begin
          case (EX_op[2:0])
            3'b000: begin alu_out = add_res; alu_ovf = ovf_add; end
            3'b001: alu_out = add_res;
            3'b010: alu_out = {31'b0, $signed(a_fwd) < $signed(alu_b)};
            3'b011: alu_out = {31'b0, a_fwd < alu_b};
            3'b100: alu_out = a_fwd & alu_b;
            3'b101: alu_out = a_fwd | alu_b;
            3'b110: alu_out = a_fwd ^ alu_b;
            default: alu_out = {EX_IMM[15:0], 16'h0000};
          endcase
        end else begin
          case (EX_func)
            6'b100000: begin alu_out = add_res; alu_ovf = ovf_add; end
            6'b100001: alu_out = add_res;
            6'b100010: begin alu_out = sub_res; alu_ovf = ovf_sub; end
            6'b100011: alu_out = sub_res;
            6'b100100: alu_out = a_fwd & alu_b;
            6'b100101: alu_out = a_fwd | alu_b;
            6'b100110: alu_out = a_fwd ^ alu_b;
            6'b100111: alu_out = ~(a_fwd | alu_b);
            6'b101010: alu_out = {31'b0, $signed(a_fwd) < $signed(alu_b)};
            6'b101011: alu_out = {31'b0, a_fwd < alu_b};
            default:   alu_out = '0;
          endcase
        end
      end
      default: alu_out = '0;
    endcase
  end

  // Variable shifts take the amount from rs; fixed shifts from the shamt field.
  assign sh_amt = EX_func[2] ? a_fwd[4:0] : EX_shamt;
  always_comb begin
    shift_out = '0;
    case (EX_func[1:0])
      2'b00:   shift_out = b_fwd << sh_amt;
      2'b10:   shift_out = b_fwd >> sh_amt;
      2'b11:   shift_out = $signed(b_fwd) >>> sh_amt;
      default: shift_out = '0;
    endcase
  end

  assign EX_ALU_result = EX_Sftmd ? shift_out : alu_out;
  assign Overflow      = ~EX_Sftmd & alu_ovf;
  assign Zero          = (EX_ALU_result == 32'h0);
  assign Negative      = a_fwd[31];
  assign Positive      = ~a_fwd[31] & (a_fwd != 32'h0);

  assign Waddr   = EX_Jal ? 5'd31 : ((EX_Regdst || EX_Jalr) ? EX_write_address_1 : EX_write_address_0);
  assign rd_data = (EX_Jal || EX_Jalr) ? EX_opcplus4 :
                   EX_Mfhi ? hi : EX_Mflo ? lo : EX_ALU_result;

  assign r_type   = (EX_Aluop == 2'b10) && !EX_I_format;
  assign mult_op  = r_type && (EX_func[5:1] == 5'b01100);
  assign product  = $signed({~EX_func[0] & a_fwd[31], a_fwd}) * $signed({~EX_func[0] & b_fwd[31], b_fwd});
  assign div_zero = (b_fwd == 32'h0);
  assign Div_0    = EX_Div & div_zero;

`ifdef DIVIDER_EN
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_t       div_state, div_state_next;
  logic [CNT_W-1:0] div_cnt;
  logic [31:0]      div_rem, div_quo, div_dvs, rem_nx, quo_nx, a_mag, b_mag;
  logic [32:0]      trial;
  logic             div_start, div_last, div_done, neg_q, neg_r, a_neg, b_neg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) div_state <= DIV_IDLE;
    else        div_state <= div_state_next;
  end

  always_comb begin
    div_state_next = div_state;
    div_start      = 1'b0;
    div_last       = 1'b0;
    case (div_state)
      DIV_IDLE: if (EX_Div && !div_done && !div_zero) begin
        div_start      = 1'b1;
        div_state_next = DIV_BUSY;
      end
      DIV_BUSY: if (div_cnt == CNT_W'(DIV_CYCLES - 1)) begin
        div_last       = 1'b1;
        div_state_next = DIV_IDLE;
      end
    endcase
  end

  assign a_neg = ~EX_func[0] & a_fwd[31];
  assign b_neg = ~EX_func[0] & b_fwd[31];
  assign a_mag = a_neg ? -a_fwd : a_fwd;
  assign b_mag = b_neg ? -b_fwd : b_fwd;

  // One restoring step: shift the next dividend bit in, keep the difference if it did not go negative.
  assign trial  = {div_rem, div_quo[31]} - {1'b0, div_dvs};
  assign rem_nx = trial[32] ? {div_rem[30:0], div_quo[31]} : trial[31:0];
  assign quo_nx = {div_quo[30:0], ~trial[32]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_rem  <= '0;
      div_quo  <= '0;
      div_dvs  <= '0;
      div_cnt  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= div_last;
      if (div_start) begin
        div_rem <= '0;
        div_quo <= a_mag;
        div_dvs <= b_mag;
        div_cnt <= '0;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
      end else if (div_state == DIV_BUSY) begin
        div_rem <= rem_nx;
        div_quo <= quo_nx;
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  assign div_we   = div_last;
  assign div_hi   = neg_r ? -rem_nx : rem_nx;
  assign div_lo   = neg_q ? -quo_nx : quo_nx;
  assign EX_stall = EX_Div & ~div_done & ~div_zero;
`else
  assign div_we   = 1'b0;
  assign div_hi   = '0;
  assign div_lo   = '0;
  assign EX_stall = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (div_we) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (mult_op) begin
      hi <= product[63:32];
      lo <= product[31:0];
    end else begin
      if (EX_Mthi) hi <= a_fwd;
      if (EX_Mtlo) lo <= a_fwd;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, EX_rd_data, EX_Jrn, product[65:64]};

endmodule

// File: tb/tb_execute32.sv
// tb_execute32: directed vector table for execute32 plus HI/LO, divider and reset sequences.
module tb_execute32;
  localparam int DIV_CYCLES = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] EX_opcplus4, EX_A, EX_B, EX_rd_data, EX_IMM, EX_MEM_ALU_result, Wdata;
  logic [5:0]  EX_func, EX_op;
  logic [4:0]  EX_shamt, EX_write_address_0, EX_write_address_1;
  logic [1:0]  EX_Aluop, AluAsrc, AluBsrc, AluMsrc;
  logic        EX_Sftmd, EX_Div, EX_Alusrc, EX_I_format, EX_Jrn, EX_Jalr, EX_Jal, EX_Regdst;
  logic        EX_Mfhi, EX_Mflo, EX_Mthi, EX_Mtlo;
  logic [31:0] rd_data, EX_ALU_result, EX_rt_data;
  logic        EX_stall, Zero, Positive, Negative, Overflow, Div_0;
  logic [4:0]  Waddr;

  int checks = 0;
  int failures = 0;

  execute32 #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clock(clock), .reset(reset), .EX_opcplus4(EX_opcplus4), .EX_A(EX_A), .EX_B(EX_B),
    .EX_rd_data(EX_rd_data), .EX_IMM(EX_IMM), .EX_func(EX_func), .EX_op(EX_op),
    .EX_shamt(EX_shamt), .EX_write_address_0(EX_write_address_0),
    .EX_write_address_1(EX_write_address_1), .EX_Aluop(EX_Aluop), .EX_Sftmd(EX_Sftmd),
    .EX_Div(EX_Div), .EX_Alusrc(EX_Alusrc), .AluAsrc(AluAsrc), .AluBsrc(AluBsrc),
    .AluMsrc(AluMsrc), .EX_I_format(EX_I_format), .EX_Jrn(EX_Jrn), .EX_Jalr(EX_Jalr),
    .EX_Jal(EX_Jal), .EX_Regdst(EX_Regdst), .EX_Mfhi(EX_Mfhi), .EX_Mflo(EX_Mflo),
    .EX_Mthi(EX_Mthi), .EX_Mtlo(EX_Mtlo), .EX_MEM_ALU_result(EX_MEM_ALU_result),
    .Wdata(Wdata), .rd_data(rd_data), .EX_stall(EX_stall), .Zero(Zero),
    .Positive(Positive), .Negative(Negative), .Overflow(Overflow), .Div_0(Div_0),
    .Waddr(Waddr), .EX_ALU_result(EX_ALU_result), .EX_rt_data(EX_rt_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic        ifmt, alusrc, sftmd;
    logic [5:0]  op, func;
    logic [4:0]  shamt;
    logic [1:0]  asrc, bsrc;
    logic [31:0] a, b, imm, exmem, wdata;
    logic [31:0] exp_res;
    logic        exp_zero, exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [1:0] aluop, input logic ifmt,
                              input logic alusrc, input logic sftmd, input logic [5:0] op,
                              input logic [5:0] func, input logic [4:0] shamt,
                              input logic [1:0] asrc, input logic [1:0] bsrc,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic [31:0] exmem, input logic [31:0] wdata,
                              input logic [31:0] exp_res, input logic exp_zero, input logic exp_ovf);
    vec_t v;
    v.name = name; v.aluop = aluop; v.ifmt = ifmt; v.alusrc = alusrc; v.sftmd = sftmd;
    v.op = op; v.func = func; v.shamt = shamt; v.asrc = asrc; v.bsrc = bsrc;
    v.a = a; v.b = b; v.imm = imm; v.exmem = exmem; v.wdata = wdata;
    v.exp_res = exp_res; v.exp_zero = exp_zero; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    EX_opcplus4 = 32'h0040_0010; EX_A = '0; EX_B = '0; EX_rd_data = 32'hFFFF_FFFF;
    EX_IMM = '0; EX_MEM_ALU_result = '0; Wdata = '0; EX_func = '0; EX_op = '0;
    EX_shamt = '0; EX_write_address_0 = 5'd8; EX_write_address_1 = 5'd10;
    EX_Aluop = 2'b00; AluAsrc = 2'b00; AluBsrc = 2'b00; AluMsrc = 2'b00;
    EX_Sftmd = 0; EX_Div = 0; EX_Alusrc = 0; EX_I_format = 0; EX_Jrn = 0; EX_Jalr = 0;
    EX_Jal = 0; EX_Regdst = 0; EX_Mfhi = 0; EX_Mflo = 0; EX_Mthi = 0; EX_Mtlo = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    EX_Mfhi = 1; EX_Mflo = 0; #1;
    check({name, "_hi"}, rd_data, exp_hi);
    EX_Mfhi = 0; EX_Mflo = 1; #1;
    check({name, "_lo"}, rd_data, exp_lo);
    EX_Mflo = 0;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [5:0] func,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    idle();
    EX_Aluop = 2'b10; EX_func = func; EX_Div = 1; EX_A = a; EX_B = b;
    #1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!EX_stall) break;
      n++;
      step();
    end
    check("div_stall_cycles", n, DIV_CYCLES + 1);
    read_hilo("div", exp_hi, exp_lo);
    EX_Div = 0;
    step();
  endtask

  initial begin
    idle();
    reset = 0;
    #12;
    read_hilo("reset", 32'h0, 32'h0);
    check("reset_stall", 32'(EX_stall), 32'h0);
    reset = 1;
    step();

    vecs.push_back(mk("lui",     2'b10,1,1,0, 6'b001111,6'd0,5'd0, 2'b00,2'b00, 32'h0,32'h0,32'hFFFFFFFF, 32'h0,32'h0, 32'hFFFF0000,0,0));
    vecs.push_back(mk("addiu_wb",2'b10,1,1,0, 6'b001001,6'd0,5'd0, 2'b10,2'b00, 32'h1234,32'h0,32'h3D, 32'h0,32'h0, 32'h3D,0,0));
    vecs.push_back(mk("addiu_mem",2'b10,1,1,0,6'b001001,6'd0,5'd0, 2'b01,2'b00, 32'h1234,32'h0,32'h3D, 32'h5,32'h0, 32'h42,0,0));
    vecs.push_back(mk("sll",     2'b10,0,0,1, 6'd0,6'b000000,5'd6, 2'b00,2'b00, 32'h0,32'h1,32'h0, 32'h0,32'h0, 32'h40,0,0));
    vecs.push_back(mk("sra",     2'b10,0,0,1, 6'd0,6'b000011,5'd4, 2'b00,2'b00, 32'h0,32'h80000000,32'h0, 32'h0,32'h0, 32'hF8000000,0,0));
    vecs.push_back(mk("beq_ne",  2'b01,0,0,0, 6'd0,6'd0,5'd0, 2'b00,2'b00, 32'hC,32'h1,32'h0, 32'h0,32'h0, 32'hB,0,0));
    vecs.push_back(mk("beq_eq",  2'b01,0,0,0, 6'd0,6'd0,5'd0, 2'b00,2'b00, 32'h55,32'h55,32'h0, 32'h0,32'h0, 32'h0,1,0));
    vecs.push_back(mk("add_ovf", 2'b10,0,0,0, 6'd0,6'b100000,5'd0, 2'b00,2'b00, 32'h7FFFFFFF,32'h1,32'h0, 32'h0,32'h0, 32'h80000000,0,1));
    vecs.push_back(mk("addu",    2'b10,0,0,0, 6'd0,6'b100001,5'd0, 2'b00,2'b00, 32'h7FFFFFFF,32'h1,32'h0, 32'h0,32'h0, 32'h80000000,0,0));
    vecs.push_back(mk("slt",     2'b10,0,0,0, 6'd0,6'b101010,5'd0, 2'b00,2'b00, 32'hFFFFFFFF,32'h1,32'h0, 32'h0,32'h0, 32'h1,0,0));
    vecs.push_back(mk("sltu",    2'b10,0,0,0, 6'd0,6'b101011,5'd0, 2'b00,2'b00, 32'hFFFFFFFF,32'h1,32'h0, 32'h0,32'h0, 32'h0,1,0));
    vecs.push_back(mk("andi",    2'b10,1,1,0, 6'b001100,6'd0,5'd0, 2'b00,2'b00, 32'hFFFFFFFF,32'h0,32'hFFFF8000, 32'h0,32'h0, 32'h00008000,0,0));
    vecs.push_back(mk("slti",    2'b10,1,1,0, 6'b001010,6'd0,5'd0, 2'b00,2'b00, 32'hFFFFFFFE,32'h0,32'hFFFFFFFF, 32'h0,32'h0, 32'h1,0,0));
    vecs.push_back(mk("sltiu",   2'b10,1,1,0, 6'b001011,6'd0,5'd0, 2'b00,2'b00, 32'h00010000,32'h0,32'hFFFFFFFF, 32'h0,32'h0, 32'h0,1,0));
    vecs.push_back(mk("srav",    2'b10,0,0,1, 6'd0,6'b000111,5'd0, 2'b00,2'b00, 32'h4,32'hF0000000,32'h0, 32'h0,32'h0, 32'hFF000000,0,0));
    vecs.push_back(mk("srlv",    2'b10,0,0,1, 6'd0,6'b000110,5'd0, 2'b00,2'b00, 32'h4,32'hF0000000,32'h0, 32'h0,32'h0, 32'h0F000000,0,0));
    vecs.push_back(mk("nor",     2'b10,0,0,0, 6'd0,6'b100111,5'd0, 2'b00,2'b00, 32'h0F0F0000,32'h00FF0000,32'h0, 32'h0,32'h0, 32'hF000FFFF,0,0));
    vecs.push_back(mk("sub_ovf", 2'b10,0,0,0, 6'd0,6'b100010,5'd0, 2'b00,2'b00, 32'h80000000,32'h1,32'h0, 32'h0,32'h0, 32'h7FFFFFFF,0,1));
    vecs.push_back(mk("xori",    2'b10,1,1,0, 6'b001110,6'd0,5'd0, 2'b00,2'b00, 32'h12345678,32'h0,32'hFFFF00FF, 32'h0,32'h0, 32'h12345687,0,0));
    vecs.push_back(mk("sw_addr", 2'b00,0,1,0, 6'b101011,6'd0,5'd0, 2'b00,2'b00, 32'h1000,32'h0,32'hFFFFFFFC, 32'h0,32'h0, 32'h00000FFC,0,0));
    vecs.push_back(mk("addu_fwdb",2'b10,0,0,0,6'd0,6'b100001,5'd0, 2'b00,2'b01, 32'h1,32'h99,32'h0, 32'h10,32'h77, 32'h11,0,0));
    vecs.push_back(mk("addi_ovf",2'b10,1,1,0, 6'b001000,6'd0,5'd0, 2'b00,2'b00, 32'h7FFFFFFF,32'h0,32'h1, 32'h0,32'h0, 32'h80000000,0,1));

    foreach (vecs[i]) begin
      idle();
      EX_Aluop = vecs[i].aluop; EX_I_format = vecs[i].ifmt; EX_Alusrc = vecs[i].alusrc;
      EX_Sftmd = vecs[i].sftmd; EX_op = vecs[i].op; EX_func = vecs[i].func;
      EX_shamt = vecs[i].shamt; AluAsrc = vecs[i].asrc; AluBsrc = vecs[i].bsrc;
      EX_A = vecs[i].a; EX_B = vecs[i].b; EX_IMM = vecs[i].imm;
      EX_MEM_ALU_result = vecs[i].exmem; Wdata = vecs[i].wdata;
      #1;
      check({vecs[i].name, "_result"}, EX_ALU_result, vecs[i].exp_res);
      check({vecs[i].name, "_rd_data"}, rd_data, vecs[i].exp_res);
      check({vecs[i].name, "_zero"}, 32'(Zero), 32'(vecs[i].exp_zero));
      check({vecs[i].name, "_ovf"}, 32'(Overflow), 32'(vecs[i].exp_ovf));
      if (i == 0) check("lui_waddr", 32'(Waddr), 32'd8);
    end

    // Sign flags follow the forwarded A operand.
    idle(); EX_A = 32'h0; #1;
    check("flags_zero_a", {30'b0, Positive, Negative}, 32'h0);
    EX_A = 32'h5; #1;
    check("flags_pos_a", {30'b0, Positive, Negative}, 32'h2);
    EX_A = 32'h8000_0000; #1;
    check("flags_neg_a", {30'b0, Positive, Negative}, 32'h1);
    EX_A = 32'h5; AluAsrc = 2'b10; Wdata = 32'h8000_0000; #1;
    check("flags_fwd_a", {30'b0, Positive, Negative}, 32'h1);

    // Destination and link-value selection.
    idle(); #1;
    check("waddr_rt", 32'(Waddr), 32'd8);
    EX_Regdst = 1; #1;
    check("waddr_rd", 32'(Waddr), 32'd10);
    EX_Regdst = 0; EX_Jalr = 1; #1;
    check("waddr_jalr", 32'(Waddr), 32'd10);
    check("rd_jalr", rd_data, 32'h0040_0010);
    EX_Jalr = 0; EX_Jal = 1; EX_Mfhi = 1; #1;
    check("waddr_jal", 32'(Waddr), 32'd31);
    check("rd_jal_over_mfhi", rd_data, 32'h0040_0010);

    // Store-data forwarding.
    idle(); EX_B = 32'h11; EX_MEM_ALU_result = 32'h22; Wdata = 32'h33;
    for (int s = 0; s < 4; s++) begin
      AluMsrc = 2'(s); #1;
      check("rt_data_fwd", EX_rt_data, (s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h11);
    end

    // MULT with forwarded B, then MFHI/MFLO.
    idle(); EX_Aluop = 2'b10; EX_func = 6'b011000; EX_A = 32'hFFFF_0000;
    AluBsrc = 2'b10; Wdata = 32'h3D; EX_B = 32'h7;
    step();
    idle(); EX_Regdst = 1; EX_Mfhi = 1; #1;
    check("mfhi_rd", rd_data, 32'hFFFF_FFFF);
    check("mfhi_waddr", 32'(Waddr), 32'h0A);
    EX_Mfhi = 0; EX_Mflo = 1; #1;
    check("mflo_rd", rd_data, 32'hFFC3_0000);

    // MULTU: same operands would differ under signed multiply.
    idle(); EX_Aluop = 2'b10; EX_func = 6'b011001; EX_A = 32'hFFFF_FFFF; EX_B = 32'h2;
    step();
    idle();
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    idle(); EX_Mthi = 1; EX_A = 32'hDEAD_BEEF;
    step();
    idle(); EX_Mtlo = 1; AluAsrc = 2'b01; EX_MEM_ALU_result = 32'hCAFE_F00D;
    step();
    idle();
    read_hilo("mthilo", 32'hDEAD_BEEF, 32'hCAFE_F00D);

`ifdef DIVIDER_EN
    run_div(32'd100, 32'd7, 6'b011011, 32'd2, 32'd14);
    run_div(32'hFFFF_FFF9, 32'd2, 6'b011010, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    idle(); EX_Aluop = 2'b10; EX_func = 6'b011010; EX_Div = 1; EX_A = 32'd9; EX_B = 32'd0; #1;
    check("div0_flag", 32'(Div_0), 32'h1);
    check("div0_stall", 32'(EX_stall), 32'h0);
    step();
    read_hilo("div0_keep", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Start a divide, then reset part-way through.
    idle(); EX_Aluop = 2'b10; EX_func = 6'b011011; EX_Div = 1; EX_A = 32'd100; EX_B = 32'd7;
    for (int c = 0; c < 5; c++) step();
    check("mid_div_stall", 32'(EX_stall), 32'h1);
`else
    idle(); EX_Aluop = 2'b10; EX_func = 6'b011010; EX_Div = 1; EX_A = 32'hFFFF_FFF9; EX_B = 32'd2; #1;
    check("nodiv_stall", 32'(EX_stall), 32'h0);
    check("nodiv_div0_clear", 32'(Div_0), 32'h0);
    step();
    read_hilo("nodiv_keep", 32'hDEAD_BEEF, 32'hCAFE_F00D);
    EX_B = 32'd0; #1;
    check("nodiv_div0_flag", 32'(Div_0), 32'h1);
    check("nodiv_div0_stall", 32'(EX_stall), 32'h0);
`endif

    reset = 0;
    EX_Div = 0;
    #1;
    check("reset_drop_stall", 32'(EX_stall), 32'h0);
    read_hilo("reset_clear", 32'h0, 32'h0);
    reset = 1;
    step();
    idle(); #1;
    check("post_reset_stall", 32'(EX_stall), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
